cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 153 +++++++++++++++
 tb/tb_cache_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// rtl/cache_control.sv - direct-mapped write-back cache controller with CHECK/WRITEBACK/FILL FSM
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   mem_read, mem_write      CPU request, held until mem_resp
//   mem_address, mem_wdata   CPU byte address and write word
//   mem_byte_enable          byte lanes of mem_wdata to merge on a write hit
//   mem_rdata, mem_resp      addressed word of the selected line, one-cycle completion
//   pmem_read, pmem_write    line fill / line writeback request, held until pmem_resp
//   pmem_address             line-aligned memory address
//   pmem_wdata, pmem_rdata   line written back / line returned by a fill
//   pmem_resp                memory completion for the current pmem request
module cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                mem_address,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_byte_enable,
    output logic [31:0]                mem_rdata,
    output logic                       mem_resp,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [31:0]                pmem_address,
    output logic [(8<<s_offset)-1:0]   pmem_wdata,
    input  logic [(8<<s_offset)-1:0]   pmem_rdata,
    input  logic                       pmem_resp
);

    localparam int num_sets  = 1 << s_index;
    localparam int line_bits = 8 << s_offset;
    localparam int word_bits = s_offset - 2;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } state_t;

    state_t state, state_next;

    logic [num_sets-1:0]  valid_arr;
    logic [num_sets-1:0]  dirty_arr;
    logic [s_tag-1:0]     tag_arr  [num_sets];
    logic [line_bits-1:0] line_arr [num_sets];

    logic [s_tag-1:0]     addr_tag;
    logic [s_index-1:0]   idx;
    logic [word_bits-1:0] word_sel;
    logic [s_offset+2:0]  word_off;
    logic [1:0]           unused_addr_bits;

    logic [s_tag-1:0]     cur_tag;
    logic [line_bits-1:0] cur_line;
    logic [line_bits-1:0] merged_line;
    logic [31:0]          old_word;
    logic [31:0]          new_word;
    logic                 hit;
    logic                 request;

    assign addr_tag         = mem_address[31 -: s_tag];
    assign idx              = mem_address[s_offset +: s_index];
    assign word_sel         = mem_address[s_offset-1:2];
    assign word_off         = {word_sel, 5'b0};
    assign unused_addr_bits = mem_address[1:0];

    assign cur_tag   = tag_arr[idx];
    assign cur_line  = line_arr[idx];
    assign hit       = valid_arr[idx] && (cur_tag == addr_tag);
    assign request   = mem_read || mem_write;
    assign old_word  = cur_line[word_off +: 32];
    // Read data always reflects the stored line, so a combined read+write
    // returns the word as it was before this cycle's merge.
    assign mem_rdata = old_word;

    always_comb begin
        new_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                new_word[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
        merged_line = cur_line;
        merged_line[word_off +: 32] = new_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CHECK;
            valid_arr <= '0;
            dirty_arr <= '0;
        end else begin
            state <= state_next;
            if (state == CHECK && mem_write && hit) begin
                line_arr[idx]  <= merged_line;
                dirty_arr[idx] <= 1'b1;
            end
            if (state == FILL && pmem_resp) begin
                line_arr[idx]  <= pmem_rdata;
                tag_arr[idx]   <= addr_tag;
                valid_arr[idx] <= 1'b1;
                dirty_arr[idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            CHECK: begin
                if (request) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else if (valid_arr[idx] && dirty_arr[idx]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {cur_tag, idx, {s_offset{1'b0}}};
                pmem_wdata   = cur_line;
                if (pmem_resp) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_tag, idx, {s_offset{1'b0}}};
                // The completed fill becomes a hit in CHECK on the next cycle.
                if (pmem_resp) begin
                    state_next = CHECK;
                end
            end
            default: begin
                state_next = CHECK;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - self-checking bench for cache_control
module tb_cache_control;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cache_control dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  sb_q [$];
    logic [255:0] ref_mem  [logic [31:0]];
    logic [255:0] back_mem [logic [31:0]];

    function automatic logic [255:0] pattern(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[32*w +: 32] = la ^ (32'h0101_0101 * 32'(w)) ^ 32'hA5A5_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] back_line(input logic [31:0] la);
        if (back_mem.exists(la)) return back_mem[la];
        return pattern(la);
    endfunction

    // CPU-visible contents: written lines, else whatever memory holds.
    function automatic logic [255:0] ref_line(input logic [31:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return back_line(la);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/mem_resp"},     256'(mem_resp),     256'(0));
        check({tag, "/pmem_read"},    256'(pmem_read),    256'(0));
        check({tag, "/pmem_write"},   256'(pmem_write),   256'(0));
        check({tag, "/pmem_address"}, 256'(pmem_address), 256'(0));
        check({tag, "/pmem_wdata"},   pmem_wdata,         256'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_mem.delete();
        #1;
        check_idle("post_reset");
    endtask

    // Drives one CPU request, plays the memory side, and checks the result.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int exp_wb, input int exp_fill,
                          input logic [31:0] exp_wb_addr);
        logic [31:0]  la;
        logic [255:0] l;
        int wb_n, fill_n, lat, resp_cyc;
        la = {addr[31:5], 5'b0};
        wb_n = 0; fill_n = 0; lat = 0; resp_cyc = -1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wdata; mem_byte_enable = be;
        l = ref_line(la);
        sb_q.push_back(l[32*addr[4:2] +: 32]);
        for (int cyc = 0; cyc < 40 && resp_cyc < 0; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                pmem_resp = 1'b0;
            end
            #1;
            check({tag, "/pmem_excl"}, 256'(pmem_read & pmem_write), 256'(0));
            if (mem_resp) begin
                resp_cyc = cyc;
                check({tag, "/rdata"}, 256'(mem_rdata), 256'(sb_q.pop_front()));
            end else if (pmem_write) begin
                if (lat == 0) begin
                    check({tag, "/wb_addr"}, 256'(pmem_address), 256'(exp_wb_addr));
                    check({tag, "/wb_data"}, pmem_wdata, ref_line(pmem_address));
                end
                lat++;
                if (lat == 3) begin
                    back_mem[pmem_address] = pmem_wdata;
                    pmem_resp = 1'b1; lat = 0; wb_n++;
                end
            end else if (pmem_read) begin
                if (lat == 0) begin
                    check({tag, "/fill_addr"}, 256'(pmem_address), 256'(la));
                end
                lat++;
                if (lat == 3) begin
                    pmem_rdata = back_line(pmem_address);
                    pmem_resp = 1'b1; lat = 0; fill_n++;
                end
            end
        end
        check({tag, "/completed"}, 256'(resp_cyc >= 0), 256'(1));
        if (resp_cyc < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
        check({tag, "/wb_count"},   256'(wb_n),   256'(exp_wb));
        check({tag, "/fill_count"}, 256'(fill_n), 256'(exp_fill));
        check({tag, "/same_cycle_hit"}, 256'(resp_cyc == 0), 256'(exp_wb == 0 && exp_fill == 0));
        if (wr && resp_cyc >= 0) begin
            l = ref_line(la);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) l[32*addr[4:2] + 8*b +: 8] = wdata[8*b +: 8];
            end
            ref_mem[la] = l;
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        check_idle({tag, "/idle_after"});
    endtask

    initial begin
        logic [255:0] l;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        l = pattern(32'h0000_0100);
        l[63:32] = 32'hDEAD_BEEF;
        back_mem[32'h0000_0100] = l;

        do_reset();

        access("cold_read",      1'b1, 1'b0, 32'h0000_0104, 32'h0,          4'b0000, 0, 1, 32'h0);
        check("cold_read_word",  256'(ref_line(32'h0000_0100) >> 32) & 256'hFFFF_FFFF, 256'hDEAD_BEEF);
        access("write_hit",      1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0011, 0, 0, 32'h0);
        access("reread_hit",     1'b1, 1'b0, 32'h0000_0104, 32'h0,          4'b0000, 0, 0, 32'h0);
        check("merged_word",     256'(ref_line(32'h0000_0100) >> 32) & 256'hFFFF_FFFF, 256'hDEAD_3344);
        access("dirty_conflict", 1'b1, 1'b0, 32'h0001_0104, 32'h0,          4'b0000, 1, 1, 32'h0000_0100);
        access("clean_conflict", 1'b1, 1'b0, 32'h0002_0108, 32'h0,          4'b0000, 0, 1, 32'h0);
        access("rd_wr_both",     1'b1, 1'b1, 32'h0002_0108, 32'hCAFE_F00D, 4'b1111, 0, 0, 32'h0);
        access("rd_after_both",  1'b1, 1'b0, 32'h0002_0108, 32'h0,          4'b0000, 0, 0, 32'h0);
        access("set7_fill",      1'b1, 1'b0, 32'h0000_00E4, 32'h0,          4'b0000, 0, 1, 32'h0);
        access("set7_write",     1'b0, 1'b1, 32'h0000_00E4, 32'hAABB_CCDD, 4'b1100, 0, 0, 32'h0);
        access("set0_evict",     1'b1, 1'b0, 32'h1000_0000, 32'h0,          4'b0000, 1, 1, 32'h0002_0100);
        access("set7_untouched", 1'b1, 1'b0, 32'h0000_00E4, 32'h0,          4'b0000, 0, 0, 32'h0);

        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = '1;
        #1;
        check_idle("stray_resp");
        @(negedge clk);
        pmem_resp = 1'b0;
        access("after_stray",    1'b1, 1'b0, 32'h0000_00E4, 32'h0,          4'b0000, 0, 0, 32'h0);

        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h3000_0044;
        @(negedge clk);
        #1;
        check("fill_before_rst", 256'(pmem_read), 256'(1));
        rst = 1'b1; pmem_resp = 1'b1; pmem_rdata = '1;
        @(negedge clk);
        rst = 1'b0; pmem_resp = 1'b0;
        ref_mem.delete();
        #1;
        check("rst_fill_pmem_read", 256'(pmem_read), 256'(0));
        check("rst_fill_mem_resp",  256'(mem_resp),  256'(0));
        @(negedge clk);
        mem_read = 1'b0;
        access("reread_after_rst", 1'b1, 1'b0, 32'h3000_0044, 32'h0,        4'b0000, 0, 1, 32'h0);
        access("dirty_lost_rst",   1'b1, 1'b0, 32'h0000_00E4, 32'h0,        4'b0000, 0, 1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
